// File: rtl/frame_seq_pkg.sv
// frame_seq_pkg: shared state encoding, coordinate widths and timing defaults
// for the frame sequencer and its round-robin arbiter.
package frame_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_BG     = 3'd2,
    S_ARB    = 3'd3,
    S_LOAD   = 3'd4,
    S_SETTLE = 3'd5,
    S_PLOT   = 3'd6,
    S_DONE   = 3'd7
  } state_e;

  localparam int X_W  = 9;
  localparam int Y_W  = 8;
  localparam int ID_W = 2;

  localparam int CLR_CNT_W = 17;
  localparam int PIX_CNT_W = 9;

  localparam int CLEAR_CYCLES_DEF = 131072;
  localparam int SPR_PIXELS_DEF   = 256;

  // Full-screen passes write every cycle, so the VGA write enable is forced on.
  function automatic logic fullscreen_pass(input state_e s);
    return (s == S_CLEAR) || (s == S_BG);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick. Grants the first candidate at or
// after the pointer, wrapping from NUM_SPR-1 back to 0.
module rr_arbiter #(
  parameter int NUM_SPR = 4,
  parameter int PTR_W   = $clog2(NUM_SPR)
) (
  input  logic [NUM_SPR-1:0] cand,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_SPR-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  logic             found;
  logic [PTR_W-1:0] k;

  // Scan candidates starting from the pointer; first hit wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_SPR; i++) begin
      k = PTR_W'((int'(ptr) + i) % NUM_SPR);
      if (!found && cand[k]) begin
        found    = 1'b1;
        grant[k] = 1'b1;
        idx      = k;
      end
    end
  end

  assign any = |cand;

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame draw controller. Clears the screen, optionally tiles
// the background, then plots each requesting sprite once, round-robin.
// Build option: define FRAME_SEQ_BG_EN to include the background pass; without
// it CLEAR goes straight to arbitration, ld_BG stays 0 and bg_done is ignored.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int NUM_SPR      = 4,
  parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF,
  parameter int SPR_PIXELS   = SPR_PIXELS_DEF,
  parameter int SETTLE       = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      frame_tick,
  input  logic [NUM_SPR-1:0]        req,
  input  logic [X_W*NUM_SPR-1:0]    spr_x,
  input  logic [Y_W*NUM_SPR-1:0]    spr_y,
  input  logic [ID_W*NUM_SPR-1:0]   spr_id,
  input  logic                      bg_done,
  output logic                      black,
  output logic                      ld_BG,
  output logic                      ld_coord,
  output logic                      ld_plot,
  output logic                      plot,
  output logic [X_W-1:0]            locX,
  output logic [Y_W-1:0]            locY,
  output logic [ID_W-1:0]           id2,
  output logic [NUM_SPR-1:0]        ack,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      overrun
);

  localparam int PTR_W = $clog2(NUM_SPR);
  localparam logic [CLR_CNT_W-1:0] CLR_LAST = CLR_CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [PIX_CNT_W-1:0] PIX_LAST = PIX_CNT_W'(SPR_PIXELS - 1);
  localparam logic [PIX_CNT_W-1:0] SET_LAST = PIX_CNT_W'(SETTLE - 1);

  state_e                 state_q, state_d;
  logic [CLR_CNT_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [PIX_CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
  logic [NUM_SPR-1:0]     served_q, served_d;
  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [X_W-1:0]         locx_q, locx_d;
  logic [Y_W-1:0]         locy_q, locy_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [NUM_SPR-1:0]     ack_q, ack_d;
  logic                   black_q, black_d;
  logic                   ld_bg_q, ld_bg_d;
  logic                   ld_coord_q, ld_coord_d;
  logic                   ld_plot_q, ld_plot_d;
  logic                   plot_q, plot_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic [NUM_SPR-1:0]     cand;
  logic [NUM_SPR-1:0]     arb_grant;
  logic [PTR_W-1:0]       arb_idx;
  logic                   arb_any;

`ifndef FRAME_SEQ_BG_EN
  logic unused_bg_done;
  assign unused_bg_done = bg_done;
`endif

  // Requesters already drawn this frame are masked out of arbitration.
  assign cand = req & ~served_q;

  rr_arbiter #(.NUM_SPR(NUM_SPR), .PTR_W(PTR_W)) u_arb (
    .cand  (cand),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Next-state, counter and registered-output logic for the frame sequence.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    pix_cnt_d = pix_cnt_q;
    served_d  = served_q;
    ptr_d     = ptr_q;
    locx_d    = locx_q;
    locy_d    = locy_q;
    id_d      = id_q;
    ack_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (frame_tick) begin
          state_d   = S_CLEAR;
          served_d  = '0;
          clr_cnt_d = '0;
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q == CLR_LAST) begin
          clr_cnt_d = '0;
`ifdef FRAME_SEQ_BG_EN
          state_d   = S_BG;
`else
          state_d   = S_ARB;
`endif
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
`ifdef FRAME_SEQ_BG_EN
      S_BG: begin
        if (bg_done) state_d = S_ARB;
      end
`endif
      S_ARB: begin
        if (!arb_any) begin
          state_d = S_DONE;
        end else begin
          // Capture the winner's fields now so they are on the outputs during LOAD.
          state_d  = S_LOAD;
          locx_d   = spr_x[int'(arb_idx)*X_W +: X_W];
          locy_d   = spr_y[int'(arb_idx)*Y_W +: Y_W];
          id_d     = spr_id[int'(arb_idx)*ID_W +: ID_W];
          ack_d    = arb_grant;
          served_d = served_q | arb_grant;
          ptr_d    = (int'(arb_idx) == NUM_SPR - 1) ? '0 : arb_idx + 1'b1;
        end
      end
      S_LOAD: begin
        state_d   = S_SETTLE;
        pix_cnt_d = '0;
      end
      S_SETTLE: begin
        if (pix_cnt_q == SET_LAST) begin
          pix_cnt_d = '0;
          state_d   = S_PLOT;
        end else begin
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
      end
      S_PLOT: begin
        if (pix_cnt_q == PIX_LAST) begin
          pix_cnt_d = '0;
          state_d   = S_ARB;
        end else begin
          pix_cnt_d = pix_cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with the state register.
    black_d    = (state_d == S_CLEAR);
`ifdef FRAME_SEQ_BG_EN
    ld_bg_d    = (state_d == S_BG);
`else
    ld_bg_d    = 1'b0;
`endif
    ld_coord_d = (state_d == S_LOAD);
    ld_plot_d  = (state_d == S_PLOT);
    // Sprite writes trail ld_plot by one cycle to match the datapath X/Y register.
    plot_d     = fullscreen_pass(state_d) | ld_plot_q;
    busy_d     = (state_d != S_IDLE);
    done_d     = (state_d == S_DONE);
  end

  // State, counters and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      clr_cnt_q  <= '0;
      pix_cnt_q  <= '0;
      served_q   <= '0;
      ptr_q      <= '0;
      locx_q     <= '0;
      locy_q     <= '0;
      id_q       <= '0;
      ack_q      <= '0;
      black_q    <= 1'b0;
      ld_bg_q    <= 1'b0;
      ld_coord_q <= 1'b0;
      ld_plot_q  <= 1'b0;
      plot_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      pix_cnt_q  <= pix_cnt_d;
      served_q   <= served_d;
      ptr_q      <= ptr_d;
      locx_q     <= locx_d;
      locy_q     <= locy_d;
      id_q       <= id_d;
      ack_q      <= ack_d;
      black_q    <= black_d;
      ld_bg_q    <= ld_bg_d;
      ld_coord_q <= ld_coord_d;
      ld_plot_q  <= ld_plot_d;
      plot_q     <= plot_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign black      = black_q;
  assign ld_BG      = ld_bg_q;
  assign ld_coord   = ld_coord_q;
  assign ld_plot    = ld_plot_q;
  assign plot       = plot_q;
  assign locX       = locx_q;
  assign locY       = locy_q;
  assign id2        = id_q;
  assign ack        = ack_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  // A tick that lands while a frame is in flight is dropped and flagged at once.
  assign overrun    = frame_tick & busy_q;

endmodule
